// File: rtl/pe_pkg.sv
// Shared types for the PE dispatcher: FSM state encoding and the FIFO entry layout.
package pe_pkg;

    localparam int PE_DATA_WIDTH  = 8;
    localparam int PE_SEL_WIDTH   = 2;
    localparam int PE_ENTRY_WIDTH = PE_DATA_WIDTH + PE_SEL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNI   = 2'd1,
        BCAST = 2'd2
    } dispatch_state_t;

    // bcast sits in the LSB so the FIFO look-ahead flag can point at bit 0
    typedef struct packed {
        logic [PE_DATA_WIDTH-1:0] data;
        logic [PE_SEL_WIDTH-1:0]  dest;
        logic                     bcast;
    } pe_entry_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with registered occupancy, combinational head read and a
// one-bit peek at the entry behind the head.
module pe_sync_fifo #(
    parameter int WIDTH    = 11,
    parameter int DEPTH    = 4,
    parameter int PEEK_BIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head,
    output logic                   peek_flag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head      = mem[rd_ptr];
    assign peek_flag = mem[rd_ptr + AW'(1)][PEEK_BIT];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_dispatch.sv
// Buffered dispatcher feeding the PE 1-to-N demux; unicast or ordered broadcast
// issue, one registered out_en pulse per delivered word.
//
//   state | meaning
//   IDLE  | FIFO empty, waiting for an entry
//   UNI   | head is unicast, waiting on dst_ready[head.dest]
//   BCAST | head is broadcast, delivering to bidx in ascending order
module pe_dispatch
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int SEL_WIDTH  = PE_SEL_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [SEL_WIDTH-1:0]         in_dest,
    input  logic                         in_bcast,
    input  logic                         flush,
    input  logic [(1 << SEL_WIDTH)-1:0]  dst_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel,
    output logic                         out_en,
    output logic                         busy
);
    localparam int NUM_OUTPUTS = 1 << SEL_WIDTH;
    localparam int CW          = $clog2(DEPTH) + 1;

    dispatch_state_t      state, state_nxt;
    logic [SEL_WIDTH-1:0] bidx, bidx_nxt;
    logic [SEL_WIDTH-1:0] target;
    pe_entry_t            in_entry, head;
    logic [CW-1:0]        count, count_after;
    logic                 full, empty, peek_bcast, new_head_bcast;
    logic                 push, pop, issue;

    assign in_entry = '{data: in_data, dest: in_dest, bcast: in_bcast};
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;

    pe_sync_fifo #(
        .WIDTH    (DATA_WIDTH + SEL_WIDTH + 1),
        .DEPTH    (DEPTH),
        .PEEK_BIT (0)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (in_entry),
        .head      (head),
        .peek_flag (peek_bcast),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // With a single entry left, the only possible new head is a same-cycle push
    assign new_head_bcast = (count == CW'(1)) ? in_bcast : peek_bcast;

    always_comb begin
        state_nxt = state;
        bidx_nxt  = bidx;
        issue     = 1'b0;
        pop       = 1'b0;
        target    = head.dest;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = head.bcast ? BCAST : UNI;
            end
            UNI: begin
                if (dst_ready[head.dest]) begin
                    issue = 1'b1;
                    pop   = 1'b1;
                end
            end
            BCAST: begin
                target = bidx;
                if (dst_ready[bidx]) begin
                    issue    = 1'b1;
                    bidx_nxt = bidx + SEL_WIDTH'(1);
                    if (bidx == SEL_WIDTH'(NUM_OUTPUTS - 1)) begin
                        pop      = 1'b1;
                        bidx_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) begin
            if (count == CW'(1) && !push) state_nxt = IDLE;
            else                          state_nxt = new_head_bcast ? BCAST : UNI;
        end
        if (flush) begin
            state_nxt = IDLE;
            bidx_nxt  = '0;
            issue     = 1'b0;
            pop       = 1'b0;
        end
    end

    always_comb begin
        count_after = count;
        if (flush)             count_after = '0;
        else if (push && !pop) count_after = count + CW'(1);
        else if (pop && !push) count_after = count - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bidx  <= '0;
        end else begin
            state <= state_nxt;
            bidx  <= bidx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en   <= 1'b0;
            out_sel  <= '0;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            out_en <= issue;
            busy   <= issue || (count_after != '0);
            if (issue) begin
                out_sel  <= target;
                out_data <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_pe_dispatch.sv
// Bench for pe_dispatch: directed scenarios plus random traffic, all checked
// against a queue-of-deliveries reference model.
module tb_pe_dispatch;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int DEPTH = 4;
    localparam int NO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_bcast, flush, out_en, busy;
    logic [DW-1:0] in_data, out_data;
    logic [SW-1:0] in_dest, out_sel;
    logic [NO-1:0] dst_ready;

    always #5 clk = ~clk;

    pe_dispatch #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast), .flush(flush),
        .dst_ready(dst_ready), .out_data(out_data), .out_sel(out_sel),
        .out_en(out_en), .busy(busy)
    );

    typedef struct {
        logic [7:0] data;
        int         dest;
        bit         bcast;
    } ent_t;

    ent_t          q[$];
    ent_t          ent_prev;
    int            bnext;
    int            n_checks = 0;
    int            n_pass = 0;
    int            pulses;
    bit            fire_prev, flush_prev, seen, pushed5;
    logic [NO-1:0] dr_prev;
    int            first_pulse_k, fire_k, tgt;
    int            exp_en[8]  = '{0, 0, 1, 1, 0, 1, 1, 0};
    int            exp_sel[8] = '{0, 0, 0, 1, 0, 2, 3, 0};
    bit            r_v, r_bc, r_fl;
    logic [7:0]    r_d;
    int            r_dest;
    logic [NO-1:0] r_dr;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: every entry expands to its destination list; pulses consume it in order.
    task automatic model_update();
        if (flush_prev) begin
            check_val("flush_no_en", out_en, 0);
            q.delete();
            bnext = 0;
        end else begin
            if (out_en) begin
                pulses++;
                if (q.size() == 0) begin
                    check_val("spurious_en", out_en, 0);
                end else begin
                    tgt = q[0].bcast ? bnext : q[0].dest;
                    check_val("out_sel", out_sel, tgt);
                    check_val("out_data", out_data, q[0].data);
                    check_val("dst_ready_at_issue", dr_prev[out_sel], 1);
                    if (q[0].bcast && bnext < NO - 1) bnext++;
                    else begin
                        void'(q.pop_front());
                        bnext = 0;
                    end
                end
            end
            if (fire_prev) q.push_back(ent_prev);
        end
        check_val("in_ready", in_ready, q.size() < DEPTH);
        check_val("busy", busy, (q.size() != 0) || out_en);
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input int dest, input bit bc,
                       input bit fl, input logic [NO-1:0] dr);
        in_valid  = v;
        in_data   = d;
        in_dest   = dest[1:0];
        in_bcast  = bc;
        flush     = fl;
        dst_ready = dr;
        #1;
        fire_prev  = v && in_ready && !fl;
        flush_prev = fl;
        dr_prev    = dr;
        ent_prev   = '{d, dest % NO, bc};
        @(posedge clk);
        @(negedge clk);
        model_update();
    endtask

    task automatic idle(input logic [NO-1:0] dr);
        cyc(1'b0, 8'h00, 0, 1'b0, 1'b0, dr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_data = 0; in_dest = 0; in_bcast = 0;
        flush = 0; dst_ready = 0; bnext = 0; pulses = 0;
        #1;
        check_val("rst_out_en", out_en, 0);
        check_val("rst_out_sel", out_sel, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // unicast latency
        cyc(1'b1, 8'hA5, 2, 1'b0, 1'b0, 4'hF);
        check_val("t1_en_T", out_en, 0);
        idle(4'hF);
        check_val("t1_en_T1", out_en, 0);
        idle(4'hF);
        check_val("t1_en_T2", out_en, 1);
        check_val("t1_sel", out_sel, 2);
        check_val("t1_data", out_data, 8'hA5);
        idle(4'hF);
        check_val("t1_en_after", out_en, 0);
        check_val("t1_busy", busy, 0);

        // broadcast stalled at destination 2
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, 8'h3C, 0, 1'b1, 1'b0, (k < 5) ? 4'b1011 : 4'b1111);
            check_val("t2_en", out_en, exp_en[k]);
            if (exp_en[k] == 1) check_val("t2_sel", out_sel, exp_sel[k]);
        end
        check_val("t2_busy", busy, 0);

        // fill with no ready destinations
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'(8'h10 + i), i % NO, 1'b0, 1'b0, 4'h0);
            check_val("t3_in_ready", in_ready, (i < 3) ? 1 : 0);
            check_val("t3_no_en", out_en, 0);
        end
        check_val("t3_fifth_held", fire_prev, 0);

        // release: drain through pointer wrap while the held entry enters
        pushed5 = 0; first_pulse_k = -1; fire_k = -1; pulses = 0;
        for (int k = 0; k < 20 && (busy || !pushed5); k++) begin
            cyc(!pushed5, 8'h14, 0, 1'b0, 1'b0, 4'hF);
            if (fire_prev && !pushed5) begin pushed5 = 1; fire_k = k; end
            if (out_en && first_pulse_k < 0) begin
                first_pulse_k = k;
                check_val("t4_ready_after_pop", in_ready, 1);
            end
        end
        check_val("t4_push_timing", fire_k, first_pulse_k + 1);
        check_val("t4_pulses", pulses, 5);
        check_val("t4_drained", busy, 0);

        // flush mid-broadcast together with a push
        cyc(1'b1, 8'hC3, 0, 1'b1, 1'b0, 4'hF);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            idle(4'hF);
            if (out_en && out_sel == 2'd1) seen = 1;
        end
        check_val("t5_reach_sel1", seen, 1);
        cyc(1'b1, 8'h77, 1, 1'b0, 1'b1, 4'hF);
        check_val("t5_busy", busy, 0);
        check_val("t5_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            idle(4'hF);
            check_val("t5_quiet", out_en, 0);
        end
        cyc(1'b1, 8'h5A, 3, 1'b0, 1'b0, 4'hF);
        idle(4'hF);
        check_val("t5_idle_latency", out_en, 0);
        idle(4'hF);
        check_val("t5_post_en", out_en, 1);
        check_val("t5_post_data", out_data, 8'h5A);
        idle(4'hF);

        // async reset during a pulse
        cyc(1'b1, 8'h99, 1, 1'b0, 1'b0, 4'hF);
        idle(4'hF);
        idle(4'hF);
        check_val("t6_pulse", out_en, 1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_out_en", out_en, 0);
        check_val("t6_out_sel", out_sel, 0);
        check_val("t6_out_data", out_data, 0);
        check_val("t6_busy", busy, 0);
        q.delete();
        bnext = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t6_in_ready", in_ready, 1);
        @(negedge clk);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r_v    = ($urandom_range(0, 1) == 1);
            r_d    = 8'($urandom_range(0, 255));
            r_dest = $urandom_range(0, NO - 1);
            r_bc   = ($urandom_range(0, 3) == 0);
            r_fl   = ($urandom_range(0, 49) == 0);
            for (int b = 0; b < NO; b++) r_dr[b] = ($urandom_range(0, 9) < 7);
            cyc(r_v, r_d, r_dest, r_bc, r_fl, r_dr);
        end
        for (int k = 0; k < 60 && busy; k++) idle(4'hF);
        check_val("drain_busy", busy, 0);
        check_val("drain_model", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_dispatch.md
# pe_dispatch

Buffered dispatcher directly upstream of the PE 1-to-N demux. Accepts a valid/ready stream of (data, destination, broadcast flag) entries, holds them in a small FIFO, and drives the demux `data_in`/`sel`/`en` inputs. Each issue is a registered one-cycle pulse, gated by per-destination ready bits. Broadcast entries are issued to every destination in ascending order before being popped.

## Interface
- `DATA_WIDTH`, 8, payload width; equals the demux `DATA_WIDTH`
- `SEL_WIDTH`, 2, destination index width; `NUM_OUTPUTS = 1 << SEL_WIDTH`
- `DEPTH`, 4, FIFO entries; power of two, at least 2

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  FIFO can accept an entry
- `in_data`  in  DATA_WIDTH  payload
- `in_dest`  in  SEL_WIDTH  target index; ignored when `in_bcast` = 1
- `in_bcast`  in  1  deliver to all `NUM_OUTPUTS` destinations
- `flush`  in  1  synchronous clear of FIFO and FSM
- `dst_ready`  in  NUM_OUTPUTS  bit i = destination i can take a word this cycle
- `out_data`  out  DATA_WIDTH  to demux `data_in`
- `out_sel`  out  SEL_WIDTH  to demux `sel`
- `out_en`  out  1  to demux `en`; one-cycle pulse per delivered word
- `busy`  out  1  FIFO non-empty or `out_en` high

## Operation
- **Push:** on an edge where `in_valid && in_ready` and `flush` = 0, write {data, dest, bcast} at the write pointer.
- **`in_ready`:** equals `count < DEPTH`. It depends only on the registered count, never on a same-cycle pop. A full FIFO therefore refuses a push even when it pops in that cycle.
- **FSM states:**
  - IDLE: FIFO empty. Go to UNI or BCAST when `count != 0`, based on the head's bcast bit.
  - UNI: issue when `dst_ready[head.dest]` = 1, then pop. Next state is decided from the new head, or IDLE if the FIFO is empty.
  - BCAST: `bidx` starts at 0. Issue to `bidx` when `dst_ready[bidx]` = 1, then increment `bidx`. Pop on the issue to `NUM_OUTPUTS-1`, reset `bidx` to 0, and choose the next state as in UNI.
- **Issue:** registers `out_en` ← 1, `out_sel` ← target, `out_data` ← head data. On any other edge, `out_en` ← 0 and `out_sel`/`out_data` hold their previous values.
- **Back-to-back issues:** allowed, one per cycle. The next head is evaluated on the cycle after a pop.
- **No skipping:** a stalled head blocks all later entries. Broadcast never skips a non-ready destination.
- **Simultaneous push and pop:** `count` is unchanged; pointers wrap modulo `DEPTH`.
- **Flush:**
  - Next edge: `count` ← 0, pointers ← 0, `bidx` ← 0, state ← IDLE, `out_en` ← 0.
  - Flush wins over a same-cycle push and a same-cycle issue.
- **Reset:** `count` = 0, pointers 0, `bidx` 0, state IDLE, `out_en` 0, `out_sel` 0, `out_data` 0, `busy` 0, `in_ready` 1. Reset mid-broadcast discards the remaining deliveries.

## Timing
- Entry pushed at edge T into an empty FIFO:
  - the FSM leaves IDLE at edge T+1;
  - `out_en` is high in the cycle following edge T+2, given that `dst_ready` is high.
- Every output is driven from a flop; there is no combinational path from inputs to outputs except `in_ready`.
- Sustained throughput is one delivery per cycle when the target is ready. A broadcast occupies `NUM_OUTPUTS` issue cycles.
- `dst_ready` is sampled in the cycle before the edge that raises `out_en`.

## Structure
- Package `pe_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, UNI, BCAST} dispatch_state_t`
  - `typedef struct packed` FIFO entry {data, dest, bcast}, parameterized through localparam widths
- Sub-module `pe_sync_fifo`:
  - parameterized width and depth;
  - push/pop/flush, registered `count`, `full`, `empty`, combinational head read;
  - `pe_dispatch` instantiates it with entry width `DATA_WIDTH + SEL_WIDTH + 1`.

## Test plan
1. Reset, then push unicast (0xA5, dest 2) with all `dst_ready` = 1 → exactly one `out_en` pulse with `out_sel` = 2 and `out_data` = 0xA5, two cycles after the push edge; `busy` then drops to 0.
2. Push broadcast 0x3C with `dst_ready` = 4'b1011 for 5 cycles, then 4'b1111 → issues to sel 0 and 1, a stall at sel 2 with no pulse, then sel 2 and 3; pop after sel 3; four pulses total.
3. Hold `dst_ready` = 0 and push 5 entries → `in_ready` falls after the 4th push; the 5th is held upstream; no `out_en` pulses.
4. Full FIFO with `in_valid` held: release `dst_ready` → one pop per cycle; `in_ready` rises the cycle after the first pop; FIFO order is preserved through pointer wrap.
5. Assert `flush` mid-broadcast (after sel 1) together with a push → no further pulses, `count` = 0, the pushed entry is dropped, and the FSM is in IDLE.
6. Assert `rst` asynchronously while `out_en` = 1 → `out_en`, `out_sel`, `out_data` and `busy` go to 0 immediately; after release, `in_ready` = 1.
